// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM for a multi-cycle MIPS datapath with one shared ALU and one
//   shared memory. It decodes opcode once per instruction, then steps the
//   datapath through FETCH..WB and drives every datapath enable and mux
//   select. It stalls FETCH, MREAD and MWRITE until memory signals ready.
//
//   Memory handshake: mem_req (with mem_we and iord) is held high from the
//   first cycle of an access until the cycle in which mem_ready is 1. The
//   access completes in that cycle, and the FSM leaves the access state on
//   that clock edge. mem_ready is ignored whenever mem_req is low.
//
// Parameters
//   ILLEGAL_HALT  1: an unknown opcode enters HALT; 0: it is treated as a NOP
//
// Optional feature (macro MULTICYCLE_PERF_EN)
//   When defined, two extra outputs are present:
//     instr_cnt  counts transitions into FETCH from a non-IDLE state
//     stall_cnt  counts cycles with mem_req=1 and mem_ready=0
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   opcode, funct   instruction fields (IR[31:26], IR[5:0])
//   zero            ALU zero flag (used for beq)
//   mem_ready       memory access completes this cycle
//   mem_req, mem_we, iord                  memory control
//   ir_write, pc_write, pc_src             IR / PC update control
//   reg_write, reg_dst, mem_to_reg         register file control
//   alu_src_a, alu_src_b, alu_ctl          ALU operand / operation select
//   halted          FSM is in HALT
//   state           current FSM state, exposed for debug and checkers
//   instr_cnt, stall_cnt   performance counters (MULTICYCLE_PERF_EN only)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter logic ILLEGAL_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_ctl,
    output logic        halted,
`ifdef MULTICYCLE_PERF_EN
    output logic [31:0] instr_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MADDR  = 4'd3,
        S_MREAD  = 4'd4,
        S_MWB    = 4'd5,
        S_MWRITE = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t cur;
    state_t nxt;
    logic   pc_write_jump;

    // The ALU decoder resolves funct itself when alu_ctl=10, so the
    // controller never looks at it.
    logic unused_funct;
    assign unused_funct = ^funct;

    assign state = cur;

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     nxt = S_REXEC;
                    OP_LW, OP_SW: nxt = S_MADDR;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_IEXEC;
                    default:      nxt = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MADDR:  nxt = (opcode == OP_SW) ? S_MWRITE : S_MREAD;
            S_MREAD:  nxt = mem_ready ? S_MWB : S_MREAD;
            S_MWB:    nxt = S_FETCH;
            S_MWRITE: nxt = mem_ready ? S_FETCH : S_MWRITE;
            S_REXEC:  nxt = S_RWB;
            S_RWB:    nxt = S_FETCH;
            S_IEXEC:  nxt = S_IWB;
            S_IWB:    nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_IDLE;
        endcase
    end

    // State and Moore outputs are registered together: outputs are decoded
    // from the next state so they line up with the state they belong to.
    // The asynchronous reset therefore clears every output (mem_req included)
    // in the same instant as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur           <= S_IDLE;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            iord          <= 1'b0;
            pc_write_jump <= 1'b0;
            pc_src        <= 2'b00;
            reg_write     <= 1'b0;
            reg_dst       <= 1'b0;
            mem_to_reg    <= 1'b0;
            alu_src_a     <= 1'b0;
            alu_src_b     <= 2'b00;
            alu_ctl       <= 2'b00;
            halted        <= 1'b0;
        end else begin
            cur           <= nxt;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            iord          <= 1'b0;
            pc_write_jump <= 1'b0;
            pc_src        <= 2'b00;
            reg_write     <= 1'b0;
            reg_dst       <= 1'b0;
            mem_to_reg    <= 1'b0;
            alu_src_a     <= 1'b0;
            alu_src_b     <= 2'b00;
            alu_ctl       <= 2'b00;
            halted        <= 1'b0;
            case (nxt)
                S_FETCH: begin
                    mem_req   <= 1'b1;
                    alu_src_b <= 2'b01;
                end
                // Branch target is computed here while the ALU is idle.
                S_DECODE: alu_src_b <= 2'b11;
                S_MADDR, S_IEXEC: begin
                    alu_src_a <= 1'b1;
                    alu_src_b <= 2'b10;
                end
                S_MREAD: begin
                    mem_req <= 1'b1;
                    iord    <= 1'b1;
                end
                S_MWB: begin
                    reg_write  <= 1'b1;
                    mem_to_reg <= 1'b1;
                end
                S_MWRITE: begin
                    mem_req <= 1'b1;
                    mem_we  <= 1'b1;
                    iord    <= 1'b1;
                end
                S_REXEC: begin
                    alu_src_a <= 1'b1;
                    alu_ctl   <= 2'b10;
                end
                S_RWB: begin
                    reg_write <= 1'b1;
                    reg_dst   <= 1'b1;
                end
                S_IWB: reg_write <= 1'b1;
                S_BRANCH: begin
                    alu_src_a <= 1'b1;
                    alu_ctl   <= 2'b01;
                    pc_src    <= 2'b01;
                end
                S_JUMP: begin
                    pc_src        <= 2'b10;
                    pc_write_jump <= 1'b1;
                end
                S_HALT: halted <= 1'b1;
                default: ;
            endcase
        end
    end

    // Mealy terms: IR/PC load only in the cycle the fetch completes, and the
    // branch PC load follows the live zero flag.
    assign ir_write = (cur == S_FETCH) && mem_ready;
    assign pc_write = pc_write_jump
                    || ((cur == S_FETCH) && mem_ready)
                    || ((cur == S_BRANCH) && zero);

`ifdef MULTICYCLE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            // The dead cycle after reset is not an instruction boundary.
            if ((nxt == S_FETCH) && (cur != S_FETCH) && (cur != S_IDLE))
                instr_cnt <= instr_cnt + 32'd1;
            if (mem_req && !mem_ready)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
